// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: AXI-Stream beat layout and TX arbiter state encoding.
package eth_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} arb_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic                   tuser;
  } axis64_t;

endpackage

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter from two AXI-Stream frame sources onto the 10G MAC TX stream,
// with optional post-frame idle gap and per-port frame counters.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter logic [7:0]  gap_len = 8'd0,
  parameter int unsigned cnt_w   = 32
) (
  input  logic                   clk156,
  input  logic                   sys_rst,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s0_axis_tkeep,
  input  logic                   s0_axis_tlast,
  input  logic                   s0_axis_tuser,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s1_axis_tkeep,
  input  logic                   s1_axis_tlast,
  input  logic                   s1_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [cnt_w-1:0]       frame_cnt0,
  output logic [cnt_w-1:0]       frame_cnt1,
  output logic                   grant,
  output logic                   busy
);

  arb_state_t  state, state_nxt;
  logic        grant_q, grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic [7:0]  gap_cnt, gap_nxt;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  axis64_t     beat [2];
  axis64_t     m_beat;
  logic        m_valid;
  logic        frame_done;

  always_comb begin
    beat[0]   = '{tdata: s0_axis_tdata, tkeep: s0_axis_tkeep, tlast: s0_axis_tlast, tuser: s0_axis_tuser};
    beat[1]   = '{tdata: s1_axis_tdata, tkeep: s1_axis_tkeep, tlast: s1_axis_tlast, tuser: s1_axis_tuser};
    src_valid = {s1_axis_tvalid, s0_axis_tvalid};
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant;
    gap_nxt        = gap_cnt;
    m_beat         = '0;
    m_valid        = 1'b0;
    src_ready      = '0;
    frame_done     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (src_valid != 2'b00) begin
          state_nxt = ARB_SEND;
          // on a tie the port that did not send last wins
          grant_nxt = (&src_valid) ? ~last_grant : src_valid[1];
        end
      end
      ARB_SEND: begin
        m_beat             = beat[grant_q];
        m_valid            = src_valid[grant_q];
        src_ready[grant_q] = m_axis_tready;
        if (m_valid && m_axis_tready && m_beat.tlast) begin
          frame_done     = 1'b1;
          last_grant_nxt = grant_q;
          if (gap_len != 8'd0) begin
            state_nxt = ARB_GAP;
            gap_nxt   = gap_len - 8'd1;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      end
      ARB_GAP: begin
        if (gap_cnt == 8'd0) state_nxt = ARB_IDLE;
        else                 gap_nxt   = gap_cnt - 8'd1;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ARB_IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
      gap_cnt    <= gap_nxt;
      if (frame_done) begin
        if (grant_q) frame_cnt1 <= frame_cnt1 + cnt_w'(1);
        else         frame_cnt0 <= frame_cnt0 + cnt_w'(1);
      end
    end
  end

  always_comb begin
    s0_axis_tready = src_ready[0];
    s1_axis_tready = src_ready[1];
    m_axis_tvalid  = m_valid;
    m_axis_tdata   = m_beat.tdata;
    m_axis_tkeep   = m_beat.tkeep;
    m_axis_tlast   = m_beat.tlast;
    m_axis_tuser   = m_beat.tuser;
    grant          = grant_q;
    busy           = (state != ARB_IDLE);
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: one instance without gap (4-bit counters), one with a 5-cycle gap.
module tb_eth_tx_arb;
  import eth_pkg::*;

  logic clk156 = 1'b0;
  logic sys_rst = 1'b0;
  always #5 clk156 = ~clk156;

  logic        s0_tvalid, s0_tlast, s0_tuser, s1_tvalid, s1_tlast, s1_tuser, m_tready;
  logic [63:0] s0_tdata, s1_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep;

  logic        a_r0, a_r1, a_tvalid, a_tlast, a_tuser, a_grant, a_busy;
  logic [63:0] a_tdata;
  logic [7:0]  a_tkeep;
  logic [3:0]  a_cnt0, a_cnt1;
  logic        b_r0, b_r1, b_tvalid, b_tlast, b_tuser, b_grant, b_busy;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [31:0] b_cnt0, b_cnt1;

  eth_tx_arb #(.gap_len(8'd0), .cnt_w(4)) dut_a (
    .clk156(clk156), .sys_rst(sys_rst),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_r0), .s0_axis_tdata(s0_tdata),
    .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_r1), .s1_axis_tdata(s1_tdata),
    .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(a_tdata),
    .m_axis_tkeep(a_tkeep), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
    .frame_cnt0(a_cnt0), .frame_cnt1(a_cnt1), .grant(a_grant), .busy(a_busy));

  eth_tx_arb #(.gap_len(8'd5), .cnt_w(32)) dut_b (
    .clk156(clk156), .sys_rst(sys_rst),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(b_r0), .s0_axis_tdata(s0_tdata),
    .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast), .s0_axis_tuser(s0_tuser),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(b_r1), .s1_axis_tdata(s1_tdata),
    .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast), .s1_axis_tuser(s1_tuser),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(b_tdata),
    .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .frame_cnt0(b_cnt0), .frame_cnt1(b_cnt1), .grant(b_grant), .busy(b_busy));

  // sel picks which instance the source model and per-cycle checks observe
  logic        sel = 1'b0;
  logic        o_r0, o_r1, o_tvalid, o_tlast, o_tuser, o_grant, o_busy;
  logic [63:0] o_tdata;
  logic [7:0]  o_tkeep;
  assign o_r0     = sel ? b_r0     : a_r0;
  assign o_r1     = sel ? b_r1     : a_r1;
  assign o_tvalid = sel ? b_tvalid : a_tvalid;
  assign o_tdata  = sel ? b_tdata  : a_tdata;
  assign o_tkeep  = sel ? b_tkeep  : a_tkeep;
  assign o_tlast  = sel ? b_tlast  : a_tlast;
  assign o_tuser  = sel ? b_tuser  : a_tuser;
  assign o_grant  = sel ? b_grant  : a_grant;
  assign o_busy   = sel ? b_busy   : a_busy;

  int          nframes[2], nbeats[2], fr[2], bt[2];
  int          cyc, viol, checks, passed;
  logic [15:0] rdy_pat;
  bit          rdy_mode;
  logic [63:0] dlog[$];
  int          clog[$];
  logic        vlog[$], blog[$];

  function automatic logic [63:0] mk(int p, int f, int b);
    return {16'hD00D, p[15:0], f[15:0], b[15:0]};
  endfunction

  task automatic clear_model();
    for (int p = 0; p < 2; p++) begin
      nframes[p] = 0; nbeats[p] = 1; fr[p] = 0; bt[p] = 0;
    end
    dlog.delete(); clog.delete(); vlog.delete(); blog.delete();
    cyc = 0; viol = 0; rdy_mode = 0; rdy_pat = '1;
  endtask

  task automatic drive();
    logic l0, l1;
    l0 = (bt[0] == nbeats[0] - 1);
    l1 = (bt[1] == nbeats[1] - 1);
    s0_tvalid = (fr[0] < nframes[0]);
    s0_tdata  = s0_tvalid ? mk(0, fr[0], bt[0]) : '0;
    s0_tlast  = s0_tvalid & l0;
    s0_tkeep  = !s0_tvalid ? 8'h00 : (l0 ? 8'h0F : 8'hFF);
    s0_tuser  = 1'b0;
    s1_tvalid = (fr[1] < nframes[1]);
    s1_tdata  = s1_tvalid ? mk(1, fr[1], bt[1]) : '0;
    s1_tlast  = s1_tvalid & l1;
    s1_tkeep  = !s1_tvalid ? 8'h00 : (l1 ? 8'h03 : 8'hFF);
    s1_tuser  = s1_tvalid & l1;
    m_tready  = rdy_mode ? rdy_pat[cyc % 16] : 1'b1;
  endtask

  task automatic adv(int p);
    bt[p]++;
    if (bt[p] == nbeats[p]) begin bt[p] = 0; fr[p]++; end
  endtask

  task automatic step();
    logic f0, f1, mf;
    @(negedge clk156);
    drive();
    #1;
    f0 = s0_tvalid & o_r0;
    f1 = s1_tvalid & o_r1;
    mf = o_tvalid & m_tready;
    if (f0 & f1) viol++;
    if (mf !== (f0 | f1)) viol++;
    if (f0 && {o_tdata, o_tkeep, o_tlast, o_tuser} !== {s0_tdata, s0_tkeep, s0_tlast, s0_tuser}) viol++;
    if (f1 && {o_tdata, o_tkeep, o_tlast, o_tuser} !== {s1_tdata, s1_tkeep, s1_tlast, s1_tuser}) viol++;
    if (o_busy) begin
      if ((o_grant ? o_r0 : o_r1) !== 1'b0) viol++;
    end else if ({o_r0, o_r1, o_tvalid, o_tdata, o_tkeep, o_tlast, o_tuser} !== '0) viol++;
    if (mf) begin dlog.push_back(o_tdata); clog.push_back(cyc); end
    vlog.push_back(o_tvalid);
    blog.push_back(o_busy);
    if (f0) adv(0);
    if (f1) adv(1);
    cyc++;
  endtask

  task automatic run(string name, int maxc);
    while ((fr[0] < nframes[0] || fr[1] < nframes[1]) && cyc < maxc) step();
    repeat (2) step();
    checks++;
    if (fr[0] < nframes[0] || fr[1] < nframes[1])
      $display("FAIL %s_timeout: sent %0d/%0d frames, want %0d/%0d", name, fr[0], fr[1], nframes[0], nframes[1]);
    else passed++;
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    #1;
    sys_rst = 1'b1;
    clear_model();
    drive();
    repeat (2) @(negedge clk156);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    #1;
    checks++; if ({a_tvalid, a_tdata, a_tkeep, a_tlast, a_tuser} !== '0) $display("FAIL reset_m: got %h want 0", {a_tvalid, a_tdata}); else passed++;
    checks++; if ({a_r0, a_r1} !== 2'b00) $display("FAIL reset_tready: got %b want 00", {a_r0, a_r1}); else passed++;
    checks++; if ({a_grant, a_busy} !== 2'b00) $display("FAIL reset_grant_busy: got %b want 00", {a_grant, a_busy}); else passed++;
    checks++; if ({a_cnt0, a_cnt1} !== 8'h00) $display("FAIL reset_cnt: got %h want 00", {a_cnt0, a_cnt1}); else passed++;
  endtask

  task automatic test_single_port();
    int mism = 0;
    sel = 1'b0;
    do_reset();
    nframes[0] = 3; nbeats[0] = 8;
    run("single", 200);
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 8; b++)
        if (k*8+b >= dlog.size() || dlog[k*8+b] !== mk(0, k, b) || clog[k*8+b] != 1 + 9*k + b) mism++;
    checks++; if (dlog.size() != 24) $display("FAIL single_beats: got %0d want 24", dlog.size()); else passed++;
    checks++; if (mism != 0) $display("FAIL single_order_timing: got %0d bad beats want 0", mism); else passed++;
    checks++; if (viol != 0) $display("FAIL single_protocol: got %0d violations want 0", viol); else passed++;
    checks++; if (a_cnt0 !== 4'd3 || a_cnt1 !== 4'd0) $display("FAIL single_cnt: got %0d/%0d want 3/0", a_cnt0, a_cnt1); else passed++;
  endtask

  task automatic test_round_robin();
    int mism = 0;
    int ep[4] = '{0, 1, 0, 1};
    int ef[4] = '{0, 0, 1, 1};
    sel = 1'b0;
    do_reset();
    nframes[0] = 2; nbeats[0] = 4; nframes[1] = 2; nbeats[1] = 4;
    run("rr", 200);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 4; b++)
        if (k*4+b >= dlog.size() || dlog[k*4+b] !== mk(ep[k], ef[k], b)) mism++;
    checks++; if (dlog.size() != 16) $display("FAIL rr_beats: got %0d want 16", dlog.size()); else passed++;
    checks++; if (mism != 0) $display("FAIL rr_order: got %0d bad beats want 0", mism); else passed++;
    checks++; if (viol != 0) $display("FAIL rr_protocol: got %0d violations want 0", viol); else passed++;
    checks++; if (a_cnt0 !== 4'd2 || a_cnt1 !== 4'd2) $display("FAIL rr_cnt: got %0d/%0d want 2/2", a_cnt0, a_cnt1); else passed++;
  endtask

  task automatic test_gap();
    logic [10:0] gv, gb;
    sel = 1'b1;
    do_reset();
    nframes[0] = 1; nbeats[0] = 2; nframes[1] = 1; nbeats[1] = 2;
    run("gap", 100);
    gv = '0; gb = '0;
    for (int c = 0; c < 11; c++)
      if (c < vlog.size()) begin gv[c] = vlog[c]; gb[c] = blog[c]; end
    checks++; if (gv !== 11'b110_0000_0110) $display("FAIL gap_valid: got %b want 11000000110", gv); else passed++;
    checks++; if (gb !== 11'b110_1111_1110) $display("FAIL gap_busy: got %b want 11011111110", gb); else passed++;
    checks++; if (dlog.size() != 4 || dlog[2] !== mk(1, 0, 0) || clog[2] != 9)
      $display("FAIL gap_next_frame: got %0d beats want 4 with port1 beat0 at cycle 9", dlog.size()); else passed++;
    checks++; if (b_cnt0 !== 32'd1 || b_cnt1 !== 32'd1) $display("FAIL gap_cnt: got %0d/%0d want 1/1", b_cnt0, b_cnt1); else passed++;
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    int mism = 0;
    sel = 1'b0;
    do_reset();
    rdy_mode = 1; rdy_pat = 16'b1011_0010_1100_1001;
    nframes[0] = 1; nbeats[0] = 16;
    run("bp", 300);
    for (int b = 0; b < 16; b++)
      if (b >= dlog.size() || dlog[b] !== mk(0, 0, b)) mism++;
    checks++; if (dlog.size() != 16) $display("FAIL bp_beats: got %0d want 16", dlog.size()); else passed++;
    checks++; if (mism != 0) $display("FAIL bp_order: got %0d bad beats want 0", mism); else passed++;
    checks++; if (viol != 0) $display("FAIL bp_protocol: got %0d violations want 0", viol); else passed++;
    checks++; if (a_cnt0 !== 4'd1) $display("FAIL bp_cnt: got %0d want 1", a_cnt0); else passed++;
  endtask

  task automatic test_wrap();
    int mism = 0;
    sel = 1'b0;
    do_reset();
    nframes[1] = 15; nbeats[1] = 1;
    run("wrap15", 200);
    for (int k = 0; k < 15; k++)
      if (k >= clog.size() || clog[k] != 1 + 2*k) mism++;
    checks++; if (a_cnt1 !== 4'd15) $display("FAIL wrap_cnt15: got %0d want 15", a_cnt1); else passed++;
    checks++; if (mism != 0) $display("FAIL wrap_single_beat_timing: got %0d bad beats want 0", mism); else passed++;
    nframes[1] = 16;
    run("wrap16", 200);
    checks++; if (a_cnt1 !== 4'd0) $display("FAIL wrap_cnt0: got %0d want 0", a_cnt1); else passed++;
    checks++; if (a_cnt0 !== 4'd0 || viol != 0) $display("FAIL wrap_misc: got cnt0 %0d viol %0d want 0/0", a_cnt0, viol); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    do_reset();
    nframes[0] = 2; nbeats[0] = 8;
    while (!(fr[0] == 1 && bt[0] == 3) && cyc < 100) step();
    checks++; if (a_cnt0 !== 4'd1) $display("FAIL mid_pre_cnt: got %0d want 1", a_cnt0); else passed++;
    @(negedge clk156);
    drive();
    #1;
    checks++; if (a_tvalid !== 1'b1 || a_tdata !== mk(0, 1, 3)) $display("FAIL mid_pre_beat: got %b %h want 1 %h", a_tvalid, a_tdata, mk(0, 1, 3)); else passed++;
    sys_rst = 1'b1;
    #1;
    checks++; if ({a_tvalid, a_tdata, a_tkeep, a_tlast, a_r0, a_busy} !== '0) $display("FAIL mid_abort: got %b %h want 0", a_tvalid, a_tdata); else passed++;
    clear_model();
    drive();
    repeat (2) @(negedge clk156);
    sys_rst = 1'b0;
    #1;
    checks++; if ({a_cnt0, a_cnt1, a_busy, a_grant} !== 10'd0) $display("FAIL mid_post_reset: got %h want 0", {a_cnt0, a_cnt1, a_busy, a_grant}); else passed++;
    nframes[0] = 1; nbeats[0] = 2; nframes[1] = 1; nbeats[1] = 2;
    run("mid_tie", 100);
    checks++; if (dlog.size() != 4 || dlog[0] !== mk(0, 0, 0) || dlog[2] !== mk(1, 0, 0))
      $display("FAIL mid_tie_order: got %0d beats want 4 with port0 first", dlog.size()); else passed++;
    checks++; if (a_cnt0 !== 4'd1 || a_cnt1 !== 4'd1 || viol != 0) $display("FAIL mid_tie_cnt: got %0d/%0d viol %0d want 1/1/0", a_cnt0, a_cnt1, viol); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0;
    clear_model();
    drive();
    test_reset();
    test_single_port();
    test_round_robin();
    test_gap();
    test_backpressure();
    test_wrap();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
